// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared pipeline encodings, hazard FSM states and control bundles.
package pipe_hazard_ctrl_pkg;
  localparam int REG_W = 5;
  localparam int DATA_W = 32;
  typedef enum logic [1:0] {BR_NONE = 2'b00, BR_BEQ = 2'b01, BR_BNE = 2'b10, BR_JMP = 2'b11} br_e;
  typedef enum logic [1:0] {RUN, LSTALL, MWAIT} state_e;
  typedef struct packed {
    logic pc_we;
    logic pc_sel;
    logic ifid_we;
    logic ifid_flush;
    logic idex_we;
    logic idex_flush;
    logic exmem_we;
    logic exmem_flush;
    logic memwb_bubble;
  } ctl_t;
  localparam ctl_t CTL_RUN = ctl_t'(9'b1_0_1_0_1_0_1_0_0);
  localparam ctl_t CTL_LU  = ctl_t'(9'b0_0_0_0_1_1_1_0_0);
  localparam ctl_t CTL_TKN = ctl_t'(9'b1_1_1_1_1_1_1_1_0);
  localparam ctl_t CTL_FRZ = ctl_t'(9'b0_0_0_0_0_0_0_0_1);
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// pipe_hazard_ctrl_hazard_detect: combinational load-use and taken-branch detection.
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem2r,
  input  logic [1:0]       mem_branch,
  input  logic             mem_zero,
  output logic             lu,
  output logic             taken
);
  assign lu = ex_mem2r && ex_rd != '0 && (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  assign taken = (mem_branch == BR_BEQ && mem_zero) || (mem_branch == BR_BNE && !mem_zero) ||
                 mem_branch == BR_JMP;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline sequencer for load-use stalls, branch redirects and dmem waits.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LOAD_STALL  = 1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_mem2r,
  input  logic [1:0]        mem_branch,
  input  logic              mem_zero,
  input  logic [DATA_W-1:0] mem_ext_pc,
  input  logic              mem_req,
  input  logic              dmem_ready,
  output logic              pc_we,
  output logic              pc_sel,
  output logic [DATA_W-1:0] pc_target,
  output logic              ifid_we,
  output logic              ifid_flush,
  output logic              idex_we,
  output logic              idex_flush,
  output logic              exmem_we,
  output logic              exmem_flush,
  output logic              memwb_bubble,
  output logic              timeout_err,
  output logic [15:0]       stall_cycles
);
  state_e state_q, state_d, ret_q, ret_d;
  logic [1:0] lcnt_q, lcnt_d, ret_lcnt_q, ret_lcnt_d;
  logic [7:0] tcnt_q, tcnt_d;
  logic terr_q, terr_d;
  logic [15:0] sc_q, sc_d;
  logic lu, taken, dwait;
  ctl_t ctl, ctl_o;

  pipe_hazard_ctrl_hazard_detect u_det (
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd), .ex_mem2r(ex_mem2r),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .lu(lu), .taken(taken)
  );

  assign dwait = mem_req && !dmem_ready;

  always_comb begin
    ctl = CTL_RUN;
    state_d = state_q;
    ret_d = ret_q;
    lcnt_d = lcnt_q;
    ret_lcnt_d = ret_lcnt_q;
    tcnt_d = tcnt_q;
    terr_d = terr_q;
    if (state_q == MWAIT) begin
      if (dmem_ready || int'(tcnt_q) + 1 >= MEM_TIMEOUT) begin
        state_d = ret_q;
        lcnt_d = ret_lcnt_q;
        terr_d = terr_q || !dmem_ready;
      end else begin
        ctl = CTL_FRZ;
        tcnt_d = tcnt_q + 8'd1;
      end
    end else if (dwait) begin
      ctl = CTL_FRZ;
      state_d = MWAIT;
      ret_d = state_q;
      ret_lcnt_d = lcnt_q;
      tcnt_d = 8'd1;
    end else if (taken) begin
      ctl = CTL_TKN;
      state_d = RUN;
      lcnt_d = '0;
    end else if (state_q == LSTALL) begin
      ctl = CTL_LU;
      state_d = lcnt_q <= 2'd1 ? RUN : LSTALL;
      lcnt_d = lcnt_q - 2'd1;
    end else if (lu) begin
      ctl = CTL_LU;
      if (LOAD_STALL > 1) begin
        state_d = LSTALL;
        lcnt_d = 2'(LOAD_STALL - 1);
      end
    end
    ctl_o = rst ? ctl : '0;
    sc_d = (!ctl_o.pc_we && sc_q != 16'hFFFF) ? sc_q + 16'd1 : sc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      ret_q <= RUN;
      lcnt_q <= '0;
      ret_lcnt_q <= '0;
      tcnt_q <= '0;
      terr_q <= 1'b0;
      sc_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q <= ret_d;
      lcnt_q <= lcnt_d;
      ret_lcnt_q <= ret_lcnt_d;
      tcnt_q <= tcnt_d;
      terr_q <= terr_d;
      sc_q <= sc_d;
    end
  end

  assign {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush,
          memwb_bubble} = ctl_o;
  assign pc_target = ctl_o.pc_sel ? mem_ext_pc : '0;
  assign timeout_err = terr_q;
  assign stall_cycles = sc_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench; each driven cycle queues its expected outputs.
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic [4:0] rs, rt;
    logic ut;
    logic [4:0] rd;
    logic m2r;
    logic [1:0] br;
    logic z;
    logic [31:0] ext;
    logic req, rdy;
  } in_t;
  typedef struct {
    int n;
    logic [8:0] c;
    logic [31:0] t;
    logic te;
    logic [15:0] s;
    logic pw2;
  } exp_t;

  localparam logic [8:0] NORM = 9'b1_0_1_0_1_0_1_0_0;
  localparam logic [8:0] LU   = 9'b0_0_0_0_1_1_1_0_0;
  localparam logic [8:0] TKN  = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] FRZ  = 9'b0_0_0_0_0_0_0_0_1;

  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0;
  logic id_uses_rt = 1'b0, ex_mem2r = 1'b0, mem_zero = 1'b0, mem_req = 1'b0, dmem_ready = 1'b0;
  logic [1:0] mem_branch = '0;
  logic [31:0] mem_ext_pc = '0;
  logic pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush, memwb_bubble;
  logic timeout_err;
  logic [31:0] pc_target;
  logic [15:0] stall_cycles;
  logic pc_we2, pc_sel2, ifid_we2, ifid_flush2, idex_we2, idex_flush2, exmem_we2, exmem_flush2;
  logic memwb_bubble2, timeout_err2;
  logic [31:0] pc_target2;
  logic [15:0] stall_cycles2;
  logic [8:0] ctl1;
  int checks = 0, errors = 0, n = 0;
  exp_t q[$];
  exp_t e;

  assign ctl1 = {pc_we, pc_sel, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush,
                 memwb_bubble};

  pipe_hazard_ctrl #(.LOAD_STALL(1), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_mem2r(ex_mem2r), .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_ext_pc(mem_ext_pc),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .pc_we(pc_we), .pc_sel(pc_sel),
    .pc_target(pc_target), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_we(idex_we),
    .idex_flush(idex_flush), .exmem_we(exmem_we), .exmem_flush(exmem_flush),
    .memwb_bubble(memwb_bubble), .timeout_err(timeout_err), .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.LOAD_STALL(3), .MEM_TIMEOUT(4)) dut2 (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_rd(ex_rd),
    .ex_mem2r(ex_mem2r), .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_ext_pc(mem_ext_pc),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .pc_we(pc_we2), .pc_sel(pc_sel2),
    .pc_target(pc_target2), .ifid_we(ifid_we2), .ifid_flush(ifid_flush2), .idex_we(idex_we2),
    .idex_flush(idex_flush2), .exmem_we(exmem_we2), .exmem_flush(exmem_flush2),
    .memwb_bubble(memwb_bubble2), .timeout_err(timeout_err2), .stall_cycles(stall_cycles2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int step, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", tag, step, act, exp);
    end
  endtask

  function automatic in_t inp(input logic [4:0] rs, rt, input logic ut, input logic [4:0] rd,
                              input logic m2r, input logic [1:0] br, input logic z,
                              input logic [31:0] ext, input logic req, rdy);
    return '{rs: rs, rt: rt, ut: ut, rd: rd, m2r: m2r, br: br, z: z, ext: ext, req: req, rdy: rdy};
  endfunction

  task automatic apply(input in_t i);
    {id_rs, id_rt, id_uses_rt, ex_rd, ex_mem2r, mem_branch, mem_zero, mem_ext_pc, mem_req,
     dmem_ready} = i;
  endtask

  task automatic step(input in_t i, input logic [8:0] c, input logic [31:0] t, input logic te,
                      input logic [15:0] s, input logic pw2);
    @(posedge clk);
    #1;
    apply(i);
    q.push_back('{n: n, c: c, t: t, te: te, s: s, pw2: pw2});
    n++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ctl", e.n, 32'(ctl1), 32'(e.c));
      chk("pc_target", e.n, pc_target, e.t);
      chk("timeout_err", e.n, 32'(timeout_err), 32'(e.te));
      chk("stall_cycles", e.n, 32'(stall_cycles), 32'(e.s));
      chk("pc_we_ls3", e.n, 32'(pc_we2), 32'(e.pw2));
    end
  end

  initial begin
    in_t idle, wt;
    idle = inp(0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 0, 0);
    wt = inp(0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 1, 0);
    step(idle, 9'h0, 0, 0, 0, 0);
    @(negedge clk);
    #1 rst = 1'b1;
    step(idle, NORM, 0, 0, 0, 1);
    step(inp(8, 0, 0, 8, 1, 2'b00, 0, 32'h0, 0, 0), LU, 0, 0, 0, 0);
    step(idle, NORM, 0, 0, 1, 0);
    step(idle, NORM, 0, 0, 1, 0);
    step(idle, NORM, 0, 0, 1, 1);
    step(inp(0, 0, 0, 0, 1, 2'b00, 0, 32'h0, 0, 0), NORM, 0, 0, 1, 1);
    step(inp(1, 9, 0, 9, 1, 2'b00, 0, 32'h0, 0, 0), NORM, 0, 0, 1, 1);
    step(inp(1, 9, 1, 9, 1, 2'b00, 0, 32'h0, 0, 0), LU, 0, 0, 1, 0);
    step(inp(8, 0, 0, 8, 1, 2'b01, 1, 32'h0040_0020, 0, 0), TKN, 32'h0040_0020, 0, 2, 1);
    step(inp(8, 0, 0, 8, 1, 2'b01, 0, 32'h0040_0020, 0, 0), LU, 0, 0, 2, 0);
    step(inp(0, 0, 0, 0, 0, 2'b10, 0, 32'h0040_0020, 0, 0), TKN, 32'h0040_0020, 0, 3, 1);
    step(inp(0, 0, 0, 0, 0, 2'b11, 1, 32'h1234_5678, 0, 0), TKN, 32'h1234_5678, 0, 3, 1);
    step(wt, FRZ, 0, 0, 3, 0);
    step(wt, FRZ, 0, 0, 4, 0);
    step(wt, FRZ, 0, 0, 5, 0);
    step(inp(0, 0, 0, 0, 0, 2'b00, 0, 32'h0, 1, 1), NORM, 0, 0, 6, 1);
    step(idle, NORM, 0, 0, 6, 1);
    step(wt, FRZ, 0, 0, 6, 0);
    step(wt, FRZ, 0, 0, 7, 0);
    step(wt, FRZ, 0, 0, 8, 0);
    step(wt, NORM, 0, 0, 9, 1);
    step(idle, NORM, 0, 1, 9, 1);
    step(wt, FRZ, 0, 1, 9, 0);
    step(wt, FRZ, 0, 1, 10, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_ctl", n, 32'(ctl1), 32'h0);
    chk("rst_pc_target", n, pc_target, 32'h0);
    chk("rst_timeout_err", n, 32'(timeout_err), 32'h0);
    chk("rst_stall_cycles", n, 32'(stall_cycles), 32'h0);
    apply(idle);
    @(posedge clk);
    #2 rst = 1'b1;
    step(idle, NORM, 0, 0, 0, 1);
    step(idle, NORM, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    chk("queue_drained", n, 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog step %0d got timeout want finish", n);
    $fatal(1, "watchdog");
  end
endmodule
